// File: rtl/sdc_block_write_ctrl.sv
// Block-write sequencer: groups source bytes into SD blocks, requests each write, pads partial last blocks.
// Optional SDC_WR_ERR_EN adds sdWrErr input and sticky errFlag output.
module sdc_block_write_ctrl #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter logic [31:0] START_ADDR  = 32'h0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [31:0]      sdAddr,
  output logic             sdWrReq,
  input  logic             sdWrAck,
  output logic [7:0]       sdData,
  output logic             sdDataValid,
  input  logic             sdDataReady,
  input  logic             sdBusy,
  output logic [CNT_W-1:0] blockCount,
  output logic             busy,
  output logic             done
`ifdef SDC_WR_ERR_EN
  ,
  input  logic             sdWrErr,
  output logic             errFlag
`endif
);

  localparam int unsigned BC_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, REQ, STREAM, PAD, WAIT_BUSY, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [BC_W-1:0]  byte_q, byte_d;
  logic             stop_pend_q, stop_pend_d;
  logic             wb_first_q, wb_first_d;
  logic             xfer;
`ifdef SDC_WR_ERR_EN
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      addr_q      <= START_ADDR;
      blk_q       <= '0;
      byte_q      <= '0;
      stop_pend_q <= 1'b0;
      wb_first_q  <= 1'b0;
`ifdef SDC_WR_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      blk_q       <= blk_d;
      byte_q      <= byte_d;
      stop_pend_q <= stop_pend_d;
      wb_first_q  <= wb_first_d;
`ifdef SDC_WR_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    blk_d       = blk_q;
    byte_d      = byte_q;
    stop_pend_d = stop_pend_q;
    wb_first_d  = wb_first_q;
`ifdef SDC_WR_ERR_EN
    err_d       = err_q;
`endif
    inReady     = 1'b0;
    sdWrReq     = 1'b0;
    sdData      = '0;
    sdDataValid = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    xfer        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT_DATA;
          addr_d      = START_ADDR;
          blk_d       = '0;
          byte_d      = '0;
          stop_pend_d = 1'b0;
`ifdef SDC_WR_ERR_EN
          err_d       = 1'b0;
`endif
        end
      end
      WAIT_DATA: begin
        // No block is open here, so a stop ends the session without a request.
        if (stop || stop_pend_q) state_d = DONE;
        else if (inValid)        state_d = REQ;
      end
      REQ: begin
        sdWrReq = 1'b1;
        if (stop)    stop_pend_d = 1'b1;
        if (sdWrAck) state_d     = STREAM;
      end
      STREAM: begin
        sdData      = inData;
        sdDataValid = inValid;
        inReady     = sdDataReady;
        xfer        = inValid && sdDataReady;
        if (stop) stop_pend_d = 1'b1;
        if (!inValid && stop_pend_q) state_d = PAD;
      end
      PAD: begin
        sdDataValid = 1'b1;
        xfer        = sdDataReady;
        if (stop) stop_pend_d = 1'b1;
      end
      WAIT_BUSY: begin
        wb_first_d = 1'b0;
        if (stop) stop_pend_d = 1'b1;
`ifdef SDC_WR_ERR_EN
        if (sdWrErr) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else
`endif
        if (!wb_first_q && !sdBusy) begin
          addr_d  = addr_q + 32'd1;
          blk_d   = (&blk_q) ? blk_q : blk_q + CNT_W'(1);
          state_d = (stop_pend_q || stop) ? DONE : WAIT_DATA;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Byte counting is shared by STREAM and PAD; the final byte closes the block.
    if (xfer) begin
      if (byte_q == LAST_BYTE) begin
        byte_d     = '0;
        state_d    = WAIT_BUSY;
        wb_first_d = 1'b1;
      end else begin
        byte_d = byte_q + BC_W'(1);
      end
    end
  end

  assign sdAddr     = addr_q;
  assign blockCount = blk_q;
`ifdef SDC_WR_ERR_EN
  assign errFlag    = err_q;
`endif

endmodule

// File: tb/tb_sdc_block_write_ctrl.sv
// Self-checking bench: randomized byte streams against a queue-based block/padding reference model.
module tb_sdc_block_write_ctrl;

  localparam int unsigned BB = 512;

  logic        clk, resetN, start, stop, inValid, sdWrAck, sdDataReady, sdBusy;
  logic [7:0]  inData;
  logic        inReady, sdWrReq, sdDataValid, busy, done;
  logic [31:0] sdAddr;
  logic [7:0]  sdData;
  logic [15:0] blockCount;
  logic        inReady2, sdWrReq2, sdDataValid2, busy2, done2;
  logic [31:0] sdAddr2;
  logic [7:0]  sdData2;
  logic [15:0] blockCount2;
`ifdef SDC_WR_ERR_EN
  logic        sdWrErr, errFlag, errFlag2;
`endif

  sdc_block_write_ctrl #(.BLOCK_BYTES(BB), .START_ADDR(32'h0), .CNT_W(16)) dut (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .sdAddr(sdAddr), .sdWrReq(sdWrReq), .sdWrAck(sdWrAck),
    .sdData(sdData), .sdDataValid(sdDataValid), .sdDataReady(sdDataReady),
    .sdBusy(sdBusy), .blockCount(blockCount), .busy(busy), .done(done)
`ifdef SDC_WR_ERR_EN
    , .sdWrErr(sdWrErr), .errFlag(errFlag)
`endif
  );

  // Same stimulus, top-of-range start address to exercise address wrap.
  sdc_block_write_ctrl #(.BLOCK_BYTES(BB), .START_ADDR(32'hFFFF_FFFF), .CNT_W(16)) dut2 (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop),
    .inData(inData), .inValid(inValid), .inReady(inReady2),
    .sdAddr(sdAddr2), .sdWrReq(sdWrReq2), .sdWrAck(sdWrAck),
    .sdData(sdData2), .sdDataValid(sdDataValid2), .sdDataReady(sdDataReady),
    .sdBusy(sdBusy), .blockCount(blockCount2), .busy(busy2), .done(done2)
`ifdef SDC_WR_ERR_EN
    , .sdWrErr(sdWrErr), .errFlag(errFlag2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  sent_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] addr_q[$];
  int          ack_xfer_q[$];
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          pad_viol = 0;
  int          busy_cnt = 0;
  int          req_age = 0;
  bit          rnd_ready = 0;
  bit          rnd_gaps = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // SD writer model (ack 2 cycles into request, 10-cycle busy per block) plus output monitor.
  always begin
    @(negedge clk);
    if (!resetN) begin
      sdWrAck = 1'b0; sdBusy = 1'b0; sdDataReady = 1'b1;
      busy_cnt = 0; req_age = 0; xfer_cnt = 0;
    end else begin
      sdWrAck = 1'b0;
      if (sdWrReq) begin
        req_age++;
        if (req_age == 2) sdWrAck = 1'b1;
      end else begin
        req_age = 0;
      end
      sdBusy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      sdDataReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      if (sdDataValid && sdDataReady) begin
        got_q.push_back(sdData);
        xfer_cnt++;
        if (xfer_cnt % BB == 0) busy_cnt = 10;
      end
      if (sdWrReq && sdWrAck) begin
        addr_q.push_back(sdAddr);
        ack_xfer_q.push_back(xfer_cnt);
      end
      if (done) done_cnt++;
      if (sdDataValid && !inValid && inReady) pad_viol++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_model();
    sent_q.delete(); got_q.delete(); addr_q.delete(); ack_xfer_q.delete();
    xfer_cnt = 0; pad_viol = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers n bytes; mode 0 = incrementing pattern, 1 = random. Returns on a falling edge.
  task automatic send(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      bit fired;
      int waited;
      b = (mode == 0) ? 8'(i) : 8'($urandom);
      if (rnd_gaps && ($urandom_range(0, 3) == 0)) begin
        inValid = 1'b0;
        @(negedge clk);
      end
      inValid = 1'b1;
      inData  = b;
      fired   = 0;
      waited  = 0;
      while (!fired && waited < 200) begin
        #1 fired = inReady;
        @(negedge clk);
        waited++;
      end
      if (!fired) begin
        check("send_timeout", 32'(waited), 32'd0);
        inValid = 1'b0;
        return;
      end
      sent_q.push_back(b);
    end
    inValid = 1'b0;
  endtask

  task automatic stop_and_wait(input string tag);
    int prev;
    int waited;
    prev = done_cnt;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    waited = 0;
    while (done_cnt == prev && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - prev), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Expected output: sent bytes followed by zeros up to a whole number of blocks.
  task automatic check_stream(input string tag, input logic [31:0] base);
    int n, nb, total;
    n = sent_q.size();
    nb = (n + BB - 1) / BB;
    total = nb * BB;
    check({tag, "_stream_len"}, 32'(got_q.size()), 32'(total));
    for (int i = 0; i < total && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), (i < n) ? 32'(sent_q[i]) : 32'd0);
    check({tag, "_req_count"}, 32'(addr_q.size()), 32'(nb));
    for (int k = 0; k < nb && k < addr_q.size(); k++) begin
      check({tag, "_req_addr"}, addr_q[k], base + 32'(k));
      check({tag, "_req_after_bytes"}, 32'(ack_xfer_q[k]), 32'(k * BB));
    end
    check({tag, "_blockCount"}, 32'(blockCount), 32'(nb));
    check({tag, "_sdAddr"}, sdAddr, base + 32'(nb));
  endtask

  initial begin
    int w;
    resetN = 1'b0; start = 1'b0; stop = 1'b0; inValid = 1'b0; inData = 8'h00;
`ifdef SDC_WR_ERR_EN
    sdWrErr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_sdAddr", sdAddr, 32'h0);
    check("rst_blockCount", 32'(blockCount), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sdWrReq", 32'(sdWrReq), 32'd0);
    check("rst_sdDataValid", 32'(sdDataValid), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd0);
    check("rst_sdAddr_hi", sdAddr2, 32'hFFFF_FFFF);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // 1: one full block of a repeating pattern, session left open.
    clear_model();
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_no_req_without_data", 32'(sdWrReq), 32'd0);
    send(512, 0);
    w = 0;
    while (blockCount != 16'd1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    #1;
    check_stream("t1", 32'h0);
    check("t1_wait_data_busy", 32'(busy), 32'd1);
    check("t1_wait_data_noreq", 32'(sdWrReq), 32'd0);
    check("t5_wrap_sdAddr", sdAddr2, 32'h0);
    check("t5_wrap_blockCount", 32'(blockCount2), 32'd1);
    stop_and_wait("t1");
    check("t1_blockCount_held", 32'(blockCount), 32'd1);

    // 2: two full blocks of random data with source gaps, stop after the block boundary.
    clear_model();
    rnd_gaps = 1;
    pulse_start();
    check("t2_sdAddr_reload", sdAddr, 32'h0);
    check("t2_blockCount_clear", 32'(blockCount), 32'd0);
    send(1024, 1);
    stop_and_wait("t2");
    check_stream("t2", 32'h0);

    // 3: partial block then stop -> zero padding.
    clear_model();
    rnd_gaps = 0;
    pulse_start();
    send(100, 0);
    stop_and_wait("t3");
    check_stream("t3", 32'h0);
    check("t3_pad_inReady", 32'(pad_viol), 32'd0);

    // 4: random sink backpressure across a block boundary and padding.
    clear_model();
    rnd_ready = 1;
    rnd_gaps = 1;
    pulse_start();
    send(600, 1);
    stop_and_wait("t4");
    check_stream("t4", 32'h0);
    check("t4_pad_inReady", 32'(pad_viol), 32'd0);
    rnd_ready = 0;
    rnd_gaps = 0;

    // 6: reset in the middle of a block.
    clear_model();
    pulse_start();
    send(37, 1);
    resetN = 1'b0;
    #1;
    check("t6_rst_sdWrReq", 32'(sdWrReq), 32'd0);
    check("t6_rst_sdDataValid", 32'(sdDataValid), 32'd0);
    check("t6_rst_inReady", 32'(inReady), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_sdAddr", sdAddr, 32'h0);
    check("t6_rst_blockCount", 32'(blockCount), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    clear_model();
    pulse_start();
    send(5, 0);
    stop_and_wait("t6");
    check_stream("t6", 32'h0);

`ifdef SDC_WR_ERR_EN
    // Write error during card busy ends the session without advancing.
    clear_model();
    pulse_start();
    send(512, 0);
    w = done_cnt;
    sdWrErr = 1'b1;
    @(negedge clk);
    sdWrErr = 1'b0;
    repeat (4) @(negedge clk);
    check("err_errFlag", 32'(errFlag), 32'd1);
    check("err_sdAddr", sdAddr, 32'h0);
    check("err_blockCount", 32'(blockCount), 32'd0);
    check("err_done", 32'(done_cnt - w), 32'd1);
    repeat (12) @(negedge clk);
    check("err_flag_held", 32'(errFlag), 32'd1);
    clear_model();
    pulse_start();
    check("err_cleared_on_start", 32'(errFlag), 32'd0);
    stop_and_wait("err_next");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
